// File: rtl/pixel_pack_wr_pkg.sv
// Shared definitions for the pixel packing write engine: parameter defaults and FSM encoding.
package pixel_pack_wr_pkg;

  localparam int unsigned BitWidthDflt   = 8;
  localparam int unsigned NumChannelDflt = 3;
  localparam int unsigned AddrWidthDflt  = 32;
  localparam int unsigned DataWidthDflt  = 32;

  // Pending-byte count width; holds up to one pixel plus a partial word (0..6 transiently).
  localparam int unsigned CntWidth = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } pack_state_e;

endpackage

// File: rtl/pixel_pack_wr_byte_repack_buf.sv
// Byte buffer that appends a pixel's bytes above the pending ones and drains whole words.
module byte_repack_buf #(
  parameter int unsigned PixW = 24,
  parameter int unsigned WordW = 32,
  parameter int unsigned BufW = 48,
  parameter int unsigned CntW = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [PixW-1:0]  pix_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CntW-1:0]  cnt_o,
  output logic [WordW-1:0] word_o
);

  localparam logic [CntW-1:0] PixBytes  = CntW'(PixW / 8);
  localparam logic [CntW-1:0] WordBytes = CntW'(WordW / 8);

  logic [BufW-1:0] data_q, data_d, app;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_app;

  // Bytes at or above the count are always zero, so a flush word needs no masking.
  always_comb begin
    app     = data_q;
    cnt_app = cnt_q;
    if (push_i) begin
      app     = data_q | (BufW'(pix_i) << {cnt_q, 3'b000});
      cnt_app = cnt_q + PixBytes;
    end
  end

  always_comb begin
    data_d = app;
    cnt_d  = cnt_app;
    if (clr_i || flush_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (pop_i) begin
      data_d = app >> WordW;
      cnt_d  = cnt_app - WordBytes;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_app;
  assign word_o = app[WordW-1:0];

endmodule

// File: rtl/pixel_pack_wr.sv
// Packs a stream of multi-channel pixels into little-endian memory words with registered writes.
module pixel_pack_wr
  import pixel_pack_wr_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = BitWidthDflt,
  parameter int unsigned NUM_CHANNEL = NumChannelDflt,
  parameter int unsigned ADDR_WIDTH  = AddrWidthDflt,
  parameter int unsigned DATA_WIDTH  = DataWidthDflt
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0] i_dat,
  input  logic                             i_val,
  output logic                             o_rdy,
  input  logic                             i_end,
  output logic [ADDR_WIDTH-1:0]            o_addr,
  output logic                             o_wren,
  output logic [DATA_WIDTH-1:0]            o_wdat,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [31:0]                      o_wcnt
);

  localparam int unsigned PixW = BIT_WIDTH * NUM_CHANNEL;
  localparam logic [CntWidth-1:0] WordBytes = CntWidth'(DATA_WIDTH / 8);

  pack_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic                  wren_q, wren_d;
  logic [31:0]           wcnt_q, wcnt_d;

  logic                  clr, push, pop, flush;
  logic [CntWidth-1:0]   cnt_app;
  logic [DATA_WIDTH-1:0] word;

  byte_repack_buf #(
    .PixW (PixW),
    .WordW(DATA_WIDTH),
    .BufW (2 * PixW),
    .CntW (CntWidth)
  ) u_buf (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (clr),
    .push_i (push),
    .pix_i  (i_dat),
    .pop_i  (pop),
    .flush_i(flush),
    .cnt_o  (cnt_app),
    .word_o (word)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wren_d  = 1'b0;
    clr     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRun;
          ptr_d   = i_base_addr;
          wcnt_d  = '0;
          clr     = 1'b1;
        end
      end
      StRun: begin
        push = i_val;
        pop  = (cnt_app >= WordBytes);
        if (i_end) begin
          if (pop) begin
            state_d = (cnt_app > WordBytes) ? StFlush : StDone;
          end else if (cnt_app != '0) begin
            // Nothing else is written this edge, so the tail goes out immediately.
            flush   = 1'b1;
            state_d = StFlush;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFlush: begin
        if (cnt_app != '0) begin
          flush = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    if (pop || flush) begin
      wren_d = 1'b1;
      addr_d = ptr_q;
      wdat_d = word;
      ptr_d  = ptr_q + ADDR_WIDTH'(1);
      wcnt_d = wcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wren_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wren_q  <= wren_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign o_rdy  = (state_q == StRun);
  assign o_busy = (state_q != StIdle);
  assign o_done = (state_q == StDone);
  assign o_addr = addr_q;
  assign o_wdat = wdat_q;
  assign o_wren = wren_q;
  assign o_wcnt = wcnt_q;

endmodule

// File: tb/tb_pixel_pack_wr.sv
// Directed bench for pixel_pack_wr: write log captured on the falling edge, checked per scenario.
module tb_pixel_pack_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_base_addr = '0;
  logic [23:0] i_dat = '0;
  logic        i_val = 1'b0;
  logic        i_end = 1'b0;
  logic        o_rdy, o_wren, o_busy, o_done;
  logic [31:0] o_addr, o_wdat, o_wcnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dn = 0;
  int dcyc = -1;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  pixel_pack_wr dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_dat      (i_dat),
    .i_val      (i_val),
    .o_rdy      (o_rdy),
    .i_end      (i_end),
    .o_addr     (o_addr),
    .o_wren     (o_wren),
    .o_wdat     (o_wdat),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_wcnt     (o_wcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst && o_wren) begin
      wa.push_back(o_addr);
      wd.push_back(o_wdat);
      wc.push_back(cyc);
    end
    if (rst && o_done) begin
      dn   <= dn + 1;
      dcyc <= cyc;
    end
  end

  task automatic start_op(input logic [31:0] base);
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = base;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic drive(input logic [23:0] d, input logic v, input logic e);
    i_dat = d;
    i_val = v;
    i_end = e;
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    i_val   = 1'b0;
    i_end   = 1'b0;
    i_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    total++;
    if ({o_wren, o_rdy, o_busy, o_done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {o_wren, o_rdy, o_busy, o_done});
    end
    total++;
    if ({o_addr, o_wdat, o_wcnt} !== 96'b0) begin
      bad++;
      $display("FAIL reset_regs: addr=%h wdat=%h wcnt=%h want all 0", o_addr, o_wdat, o_wcnt);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (o_rdy !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b want 0 0", o_rdy, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int b, d0;
    logic [31:0] ea[3], ed[3];
    ea = '{32'h100, 32'h101, 32'h102};
    ed = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    b  = wa.size();
    d0 = dn;
    start_op(32'h100);
    total++;
    if (o_rdy !== 1'b1 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_run: rdy=%b busy=%b want 1 1", o_rdy, o_busy);
    end
    drive(24'h030201, 1'b1, 1'b0);
    drive(24'h060504, 1'b1, 1'b0);
    drive(24'h090807, 1'b1, 1'b0);
    drive(24'h0C0B0A, 1'b1, 1'b1);
    quiet(5);
    total++;
    if (wa.size() - b !== 3) begin
      bad++;
      $display("FAIL b2b_nwrites: got %0d want 3", wa.size() - b);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (b + k >= wa.size()) begin
        bad++;
        $display("FAIL b2b_word%0d: missing want %h@%h", k, ed[k], ea[k]);
      end else if (wa[b+k] !== ea[k] || wd[b+k] !== ed[k]) begin
        bad++;
        $display("FAIL b2b_word%0d: got %h@%h want %h@%h", k, wd[b+k], wa[b+k], ed[k], ea[k]);
      end
    end
    total++;
    if (dn - d0 !== 1) begin
      bad++;
      $display("FAIL b2b_done: got %0d pulses want 1", dn - d0);
    end
    // Without a flush the done pulse coincides with the last word.
    total++;
    if (wa.size() < b + 3 || dcyc !== wc[b+2]) begin
      bad++;
      $display("FAIL b2b_noflush: done cycle %0d, last write cycle differs", dcyc);
    end
    total++;
    if (o_wcnt !== 32'd3 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_wcnt: got wcnt=%0d busy=%b want 3 0", o_wcnt, o_busy);
    end
  endtask

  task automatic test_single_flush();
    int b, d0;
    b  = wa.size();
    d0 = dn;
    start_op(32'h20);
    drive(24'hCCBBAA, 1'b1, 1'b1);
    quiet(5);
    total++;
    if (wa.size() - b !== 1) begin
      bad++;
      $display("FAIL single_nwrites: got %0d want 1", wa.size() - b);
    end else if (wa[b] !== 32'h20 || wd[b] !== 32'h00CCBBAA) begin
      bad++;
      $display("FAIL single_word: got %h@%h want 00ccbbaa@00000020", wd[b], wa[b]);
    end
    total++;
    if (dn - d0 !== 1 || wa.size() <= b || dcyc !== wc[b] + 1) begin
      bad++;
      $display("FAIL single_done: pulses=%0d cycle=%0d want 1 pulse one cycle after write",
               dn - d0, dcyc);
    end
    total++;
    if (o_wcnt !== 32'd1) begin
      bad++;
      $display("FAIL single_wcnt: got %0d want 1", o_wcnt);
    end
  endtask

  task automatic test_gaps();
    int b;
    logic [23:0] pix;
    logic [31:0] ed[4];
    ed = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h000F0E0D};
    b  = wa.size();
    start_op(32'h200);
    for (int k = 0; k < 5; k++) begin
      pix = {8'(3 * k + 3), 8'(3 * k + 2), 8'(3 * k + 1)};
      drive(pix, 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) drive(24'hDEADBE, 1'b0, 1'b0);
    end
    drive(24'hABCDEF, 1'b0, 1'b1);
    quiet(5);
    total++;
    if (wa.size() - b !== 4) begin
      bad++;
      $display("FAIL gaps_nwrites: got %0d want 4", wa.size() - b);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (b + k >= wa.size()) begin
        bad++;
        $display("FAIL gaps_word%0d: missing want %h", k, ed[k]);
      end else if (wa[b+k] !== 32'h200 + k || wd[b+k] !== ed[k]) begin
        bad++;
        $display("FAIL gaps_word%0d: got %h@%h want %h@%h", k, wd[b+k], wa[b+k], ed[k],
                 32'h200 + k);
      end
    end
    total++;
    if (wa.size() < b + 4 || dcyc !== wc[b+3] + 1 || o_wcnt !== 32'd4) begin
      bad++;
      $display("FAIL gaps_end: done cycle=%0d wcnt=%0d want done after flush, wcnt 4",
               dcyc, o_wcnt);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    start_op(32'h80);
    drive(24'h030201, 1'b1, 1'b0);
    drive(24'h060504, 1'b1, 1'b0);
    i_val = 1'b0;
    #2 rst = 1'b0;
    #1;
    b = wa.size();
    total++;
    if ({o_wren, o_rdy, o_busy, o_done} !== 4'b0 || {o_addr, o_wdat, o_wcnt} !== 96'b0) begin
      bad++;
      $display("FAIL midreset_outputs: wren=%b rdy=%b busy=%b done=%b addr=%h wdat=%h wcnt=%h",
               o_wren, o_rdy, o_busy, o_done, o_addr, o_wdat, o_wcnt);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet(3);
    total++;
    if (wa.size() !== b) begin
      bad++;
      $display("FAIL midreset_nowrite: got %0d writes want 0", wa.size() - b);
    end
    start_op(32'h40);
    drive(24'h030201, 1'b1, 1'b0);
    drive(24'h060504, 1'b1, 1'b0);
    drive(24'h090807, 1'b1, 1'b1);
    quiet(5);
    total++;
    if (wa.size() - b !== 3) begin
      bad++;
      $display("FAIL restart_nwrites: got %0d want 3", wa.size() - b);
    end else if (wa[b] !== 32'h40 || wd[b] !== 32'h04030201) begin
      bad++;
      $display("FAIL restart_first: got %h@%h want 04030201@00000040", wd[b], wa[b]);
    end else if (wa[b+2] !== 32'h42 || wd[b+2] !== 32'h00000009) begin
      bad++;
      $display("FAIL restart_flush: got %h@%h want 00000009@00000042", wd[b+2], wa[b+2]);
    end
  endtask

  task automatic test_wrap();
    int b;
    logic [23:0] pix;
    logic [31:0] ew;
    b = wa.size();
    start_op(32'hFFFF_FFFF);
    for (int k = 0; k < 8; k++) begin
      pix = {8'(3 * k + 3), 8'(3 * k + 2), 8'(3 * k + 1)};
      drive(pix, 1'b1, k == 7);
    end
    quiet(5);
    total++;
    if (wa.size() - b !== 6) begin
      bad++;
      $display("FAIL wrap_nwrites: got %0d want 6", wa.size() - b);
    end
    for (int j = 0; j < 6; j++) begin
      ew = {8'(4 * j + 4), 8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1)};
      total++;
      if (b + j >= wa.size()) begin
        bad++;
        $display("FAIL wrap_word%0d: missing want %h", j, ew);
      end else if (wa[b+j] !== 32'hFFFF_FFFF + 32'(j) || wd[b+j] !== ew) begin
        bad++;
        $display("FAIL wrap_word%0d: got %h@%h want %h@%h", j, wd[b+j], wa[b+j], ew,
                 32'hFFFF_FFFF + 32'(j));
      end
    end
    total++;
    if (o_wcnt !== 32'd6) begin
      bad++;
      $display("FAIL wrap_wcnt: got %0d want 6", o_wcnt);
    end
  endtask

  task automatic test_ignored();
    int b, d0;
    b  = wa.size();
    d0 = dn;
    drive(24'h123456, 1'b1, 1'b1);
    drive(24'h123456, 1'b1, 1'b0);
    quiet(2);
    total++;
    if (o_rdy !== 1'b0 || o_busy !== 1'b0 || wa.size() !== b || dn !== d0) begin
      bad++;
      $display("FAIL idle_val: rdy=%b busy=%b writes=%0d dones=%0d want all 0", o_rdy, o_busy,
               wa.size() - b, dn - d0);
    end
    start_op(32'h500);
    i_start     = 1'b1;
    i_base_addr = 32'h900;
    drive(24'h030201, 1'b1, 1'b0);
    i_start = 1'b0;
    total++;
    if (o_rdy !== 1'b1 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL run_start: rdy=%b busy=%b want 1 1", o_rdy, o_busy);
    end
    drive(24'h060504, 1'b1, 1'b1);
    quiet(6);
    total++;
    if (wa.size() - b !== 2) begin
      bad++;
      $display("FAIL run_start_nwrites: got %0d want 2", wa.size() - b);
    end else if (wa[b] !== 32'h500 || wd[b] !== 32'h04030201 ||
                 wa[b+1] !== 32'h501 || wd[b+1] !== 32'h00000605) begin
      bad++;
      $display("FAIL run_start_words: got %h@%h %h@%h want 04030201@500 00000605@501",
               wd[b], wa[b], wd[b+1], wa[b+1]);
    end
    total++;
    if (dn - d0 !== 1 || wa.size() < b + 2 || dcyc !== wc[b+1] + 1) begin
      bad++;
      $display("FAIL split_done: pulses=%0d cycle=%0d want 1 pulse after flush", dn - d0, dcyc);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_flush();
    test_gaps();
    test_reset_mid();
    test_wrap();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
